// File: rtl/call_stack_if.sv
// Command/status bundle between the PC datapath and the return-address stack.
interface call_stack_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             push;
  logic             pop;
  logic             clear_err;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] top;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, clear_err, data_in,
    input  top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, clear_err, data_in,
    output top, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/call_stack.sv
// Return-address stack: circular storage addressed by a write pointer, with
// occupancy tracked separately so wrap never needs a pointer comparison.
module call_stack #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b0,
  parameter int AW        = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst,
  call_stack_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW:0]      cnt;
  logic             ovf;
  logic             unf;

  logic [AW-1:0]    topIdx;
  logic             isEmpty;
  logic             isFull;
  logic             memWe;
  logic [AW-1:0]    memIdx;
  logic [AW-1:0]    wpNext;
  logic [AW:0]      cntNext;
  logic             setOvf;
  logic             setUnf;

  assign topIdx  = wp - 1'b1;
  assign isEmpty = (cnt == '0);
  assign isFull  = (cnt == FULL_CNT);

  assign bus.top       = isEmpty ? '0 : mem[topIdx];
  assign bus.count     = cnt;
  assign bus.empty     = isEmpty;
  assign bus.full      = isFull;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;

  // Decode the {push,pop} command into a storage write and next pointer/count.
  always_comb begin
    memWe   = 1'b0;
    memIdx  = wp;
    wpNext  = wp;
    cntNext = cnt;
    setOvf  = 1'b0;
    setUnf  = 1'b0;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (!isFull) begin
          memWe   = 1'b1;
          wpNext  = wp + 1'b1;
          cntNext = cnt + 1'b1;
        end else begin
          setOvf = 1'b1;
          // Circular mode: the new entry lands on the oldest slot.
          if (OVERWRITE) begin
            memWe  = 1'b1;
            wpNext = wp + 1'b1;
          end
        end
      end
      2'b01: begin
        if (!isEmpty) begin
          wpNext  = wp - 1'b1;
          cntNext = cnt - 1'b1;
        end else begin
          setUnf = 1'b1;
        end
      end
      2'b11: begin
        memWe = 1'b1;
        if (!isEmpty) begin
          memIdx = topIdx;   // replace top, occupancy unchanged
        end else begin
          wpNext  = wp + 1'b1;
          cntNext = cnt + 1'b1;
          setUnf  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Storage is never reset; writes are simply suppressed during reset.
  always_ff @(posedge clk) begin
    if (!rst && memWe) mem[memIdx] <= bus.data_in;
  end

  // Pointer, occupancy and sticky flags; a set in the clear cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      wp  <= wpNext;
      cnt <= cntNext;
      ovf <= setOvf | (ovf & ~bus.clear_err);
      unf <= setUnf | (unf & ~bus.clear_err);
    end
  end
endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: one reject-policy and one overwrite-policy instance
// driven with the same directed commands and checked against a list model.
module tb_call_stack;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [31:0] din = '0;
  bit          chkOn = 1'b0;

  int errors = 0;
  int checks = 0;

  // Model: oldest entry at index 0, newest at msz-1.
  logic [31:0] mlist [2][D];
  int          msz [2];
  bit          mof [2];
  bit          muf [2];

  always #5 clk = ~clk;

  call_stack_if #(.WIDTH(32), .DEPTH(D)) b0 ();
  call_stack_if #(.WIDTH(32), .DEPTH(D)) b1 ();

  assign b0.push = push;  assign b0.pop = pop;  assign b0.clear_err = clr;  assign b0.data_in = din;
  assign b1.push = push;  assign b1.pop = pop;  assign b1.clear_err = clr;  assign b1.data_in = din;

  call_stack #(.WIDTH(32), .DEPTH(D), .OVERWRITE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  call_stack #(.WIDTH(32), .DEPTH(D), .OVERWRITE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mtop(input int k);
    return (msz[k] == 0) ? 32'h0 : mlist[k][msz[k]-1];
  endfunction

  task automatic modelStep(input bit p, input bit po, input bit ce, input logic [31:0] d, input bit r);
    for (int k = 0; k < 2; k++) begin
      bit so = 1'b0;
      bit su = 1'b0;
      if (r) begin
        msz[k] = 0; mof[k] = 1'b0; muf[k] = 1'b0;
      end else begin
        if (p && po) begin
          if (msz[k] == 0) begin mlist[k][0] = d; msz[k] = 1; su = 1'b1; end
          else mlist[k][msz[k]-1] = d;
        end else if (p) begin
          if (msz[k] < D) begin mlist[k][msz[k]] = d; msz[k]++; end
          else begin
            so = 1'b1;
            if (k == 1) begin
              for (int i = 0; i < D-1; i++) mlist[k][i] = mlist[k][i+1];
              mlist[k][D-1] = d;
            end
          end
        end else if (po) begin
          if (msz[k] > 0) msz[k]--;
          else su = 1'b1;
        end
        mof[k] = so | (mof[k] & !ce);
        muf[k] = su | (muf[k] & !ce);
      end
    end
  endtask

  // Every cycle, compare both instances against the model on the falling edge.
  always @(negedge clk) begin
    if (chkOn) begin
      check("top0",   b0.top, mtop(0));
      check("count0", 32'(b0.count), 32'(msz[0]));
      check("empty0", 32'(b0.empty), 32'(msz[0] == 0));
      check("full0",  32'(b0.full),  32'(msz[0] == D));
      check("ovf0",   32'(b0.overflow),  32'(mof[0]));
      check("unf0",   32'(b0.underflow), 32'(muf[0]));
      check("top1",   b1.top, mtop(1));
      check("count1", 32'(b1.count), 32'(msz[1]));
      check("empty1", 32'(b1.empty), 32'(msz[1] == 0));
      check("full1",  32'(b1.full),  32'(msz[1] == D));
      check("ovf1",   32'(b1.overflow),  32'(mof[1]));
      check("unf1",   32'(b1.underflow), 32'(muf[1]));
    end
  end

  // One clock: drive inputs, let the edge happen, then advance the model.
  task automatic step(input bit p, input bit po, input bit ce, input logic [31:0] d, input bit r);
    push = p; pop = po; clr = ce; din = d; rst = r;
    @(posedge clk);
    modelStep(p, po, ce, d, r);
    #1;
    push = 1'b0; pop = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic doReset();
    step(0, 0, 0, 32'h0, 1);
  endtask

  initial begin
    #1;
    doReset();
    chkOn = 1'b1;
    check("rst_count", 32'(b0.count), 32'd0);
    check("rst_empty", 32'(b0.empty), 32'd1);
    check("rst_top",   b0.top, 32'h0);

    // Basic push/pop ordering
    step(1, 0, 0, 32'h10, 0);
    step(1, 0, 0, 32'h20, 0);
    step(1, 0, 0, 32'h30, 0);
    check("basic_count", 32'(b0.count), 32'd3);
    check("basic_top",   b0.top, 32'h30);
    check("pop_a", b0.top, 32'h30); step(0, 1, 0, 32'h0, 0);
    check("pop_b", b0.top, 32'h20); step(0, 1, 0, 32'h0, 0);
    check("pop_c", b0.top, 32'h10); step(0, 1, 0, 32'h0, 0);
    check("basic_empty", 32'(b0.empty), 32'd1);
    check("basic_noflag", 32'({b0.overflow, b0.underflow}), 32'd0);

    // Full with both policies: push 1..5 then drain
    doReset();
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 32'(i), 0);
    check("rej_full",  32'(b0.full), 32'd1);
    check("rej_top",   b0.top, 32'h4);
    check("rej_ovf",   32'(b0.overflow), 32'd1);
    check("ow_top5",   b1.top, 32'h5);
    for (int i = 4; i >= 1; i--) begin
      check("rej_pop", b0.top, 32'(i));
      step(0, 1, 0, 32'h0, 0);
    end

    // Overwrite policy: push 1..6, pops return 6,5,4,3 (wp wraps both ways)
    doReset();
    for (int i = 1; i <= 6; i++) step(1, 0, 0, 32'(i), 0);
    check("ow_count", 32'(b1.count), 32'd4);
    check("ow_ovf",   32'(b1.overflow), 32'd1);
    for (int i = 6; i >= 3; i--) begin
      check("ow_pop", b1.top, 32'(i));
      step(0, 1, 0, 32'h0, 0);
    end

    // Replace-top and empty corners
    doReset();
    step(1, 0, 0, 32'hA, 0);
    step(1, 1, 0, 32'hB, 0);
    check("repl_count", 32'(b0.count), 32'd1);
    check("repl_top",   b0.top, 32'hB);
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    check("unf_set", 32'(b0.underflow), 32'd1);
    step(1, 1, 0, 32'hC, 0);
    check("pp_empty_top", b0.top, 32'hC);
    check("pp_empty_unf", 32'(b0.underflow), 32'd1);
    // Replace while full raises no flag
    step(1, 0, 0, 32'h1, 0); step(1, 0, 0, 32'h2, 0); step(1, 0, 0, 32'h3, 0);
    step(0, 0, 1, 32'h0, 0);
    step(1, 1, 0, 32'hD, 0);
    check("repl_full_top", b1.top, 32'hD);
    check("repl_full_ovf", 32'(b1.overflow), 32'd0);

    // Flag clear and set-wins-over-clear
    doReset();
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 32'(i + 8), 0);
    step(0, 0, 1, 32'h0, 0);
    check("clr_ovf", 32'(b0.overflow), 32'd0);
    step(1, 0, 1, 32'h77, 0);
    check("setwin_ovf0", 32'(b0.overflow), 32'd1);
    check("setwin_ovf1", 32'(b1.overflow), 32'd1);

    // Reset mid-operation with a push in the reset cycle
    doReset();
    step(1, 0, 0, 32'h1, 0); step(1, 0, 0, 32'h2, 0); step(1, 0, 0, 32'h3, 0);
    step(1, 0, 0, 32'h99, 1);
    check("mid_rst_count", 32'(b0.count), 32'd0);
    check("mid_rst_empty", 32'(b0.empty), 32'd1);
    step(1, 0, 0, 32'h7, 0);
    check("mid_rst_top", b0.top, 32'h7);

    @(negedge clk);
    chkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/call_stack.md
# call_stack

Parametrised hardware return-address stack for the multicycle processor: holds PC values pushed on call and supplies them on return. Successor to the fixed single-purpose stack. Generalised in width and depth, with occupancy reporting, sticky error flags, simultaneous push/pop (replace-top) and a selectable full-stack policy (reject or overwrite oldest). Sits between the PC register (push data) and the PC mux (return address input).

## Interface
- WIDTH, 32: data width in bits (≥1).
- DEPTH, 16: number of entries; power of two, ≥2.
- OVERWRITE, 0: 0 = push when full is rejected; 1 = push when full discards the oldest entry (circular).
- AW, $clog2(DEPTH): derived pointer width; do not override.

- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- push  in  1  write data_in as the new top.
- pop  in  1  remove the current top.
- clear_err  in  1  clear the sticky overflow and underflow flags.
- data_in  in  WIDTH  value to push (PC).
- top  out  WIDTH  current top entry, combinational from storage and pointer; 0 when empty.
- count  out  AW+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: push rejected or oldest entry discarded.
- underflow  out  1  sticky: pop attempted while empty.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer wp (AW bits, wraps modulo DEPTH), and count register. top = mem[wp−1 mod DEPTH] when count>0, else 0.
- Command per cycle, evaluated on {push,pop}:
  - 00: hold.
  - 10, not full: mem[wp]←data_in; wp+1; count+1.
  - 10, full, OVERWRITE=0: no state change; overflow←1.
  - 10, full, OVERWRITE=1: mem[wp]←data_in; wp+1; count stays DEPTH (oldest lost); overflow←1.
  - 01, count>0: wp−1; count−1. Entry contents are not cleared.
  - 01, empty: no state change; underflow←1.
  - 11, count>0: replace top: mem[wp−1]←data_in; wp and count unchanged. No flag, including when full.
  - 11, empty: behaves as push (count→1, top=data_in); underflow←1.
- Flags: set conditions above. clear_err clears both flags. If a set condition occurs in the same cycle as clear_err, the set wins (flag reads 1).
- Reset: wp←0, count←0, overflow←0, underflow←0. Storage contents are not reset. rst has priority over every other input, so a push or pop in the reset cycle is ignored.

## Timing
- After reset: top=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- push/pop take effect at the edge on which they are sampled. top, count, empty and full reflect the new state in the following cycle.
- top is valid in the same cycle that pop is asserted; the processor loads it into the PC on that edge. Zero-latency return.
- No handshake: commands are single-cycle and always accepted. Errors are reported through flags only.
- Pointer wrap: wp rolls over DEPTH−1→0 on push and 0→DEPTH−1 on pop. Correctness relies on count, never on a wp comparison.

## Test plan
- Reset/basic (WIDTH=32, DEPTH=4): after rst, push 0x10, 0x20, 0x30 -> count=3, top=0x30. Pop ×3 -> top reads 0x30, 0x20, 0x10 in the pop cycles. Then empty=1, top=0, no flags set.
- Full, OVERWRITE=0: push 1,2,3,4, then 5 -> full=1, count=4, top=4, overflow=1. Pop ×4 -> 4,3,2,1.
- Full, OVERWRITE=1: push 1..6 -> count=4, overflow=1, pops return 6,5,4,3. Covers wp wrap on both push and pop.
- Replace and empty corners: push 0xA then push+pop 0xB -> count=1, top=0xB. Pop, then pop again -> underflow=1, count=0. Push+pop 0xC while empty -> count=1, top=0xC, underflow stays 1.
- Flags: with overflow=1, assert clear_err -> next cycle overflow=0. Assert clear_err together with a rejected push -> overflow=1.
- Reset mid-operation: count=3, assert rst together with push -> next cycle count=0, empty=1, flags 0. Push 0x7 -> top=0x7.
